display_bcd_ctrl: RTL and testbench
===================================

// Module: display_bcd_ctrl
// PURPOSE
//  Sequencer that feeds the 8-digit multiplexed seven-segment driver.
//  Takes three binary fields (A, B, C), converts them one at a time to two
//  BCD digits each using a shared shift-and-add-3 (double-dabble) engine, and
//  drives the eight 4-bit digit inputs of the display driver.
//  All eight outputs are updated in the same cycle, so the display never shows
//  a partial result.
// PARAMETERS
//  WIDTH  8  Width of each binary field. Legal range is 4..9.
//            The engine is 12 bits wide (3 BCD nibbles).
// PORTS
//  clock    in   1      System clock. All state changes on the rising edge.
//  reset_n  in   1      Asynchronous, active-low reset.
//  start    in   1      Request a conversion. Accepted only when busy=0.
//  val_a    in   WIDTH  Field A, shown on dig1 (tens) and dig0 (units).
//  val_b    in   WIDTH  Field B, shown on dig5 (tens) and dig4 (units).
//  val_c    in   WIDTH  Field C, shown on dig7 (tens) and dig6 (units).
//  busy     out  1      Conversion in progress.
//  done     out  1      One-cycle pulse: new digits are valid this cycle.
//  dig0..7  out  4      Digit codes to the driver. 4'hF renders as a dash.
// BEHAVIOUR
//  Reset (async, reset_n=0):
//   - state=IDLE, busy=0, done=0, staging cleared.
//   - dig0..dig7 = 4'hF (all dashes).
//   - A reset in the middle of a conversion aborts it; no partial digits reach the outputs.
//  Accept:
//   - start=1 at a rising edge with busy=0 captures val_a/b/c into shadow registers.
//   - Input changes after that edge have no effect on the running conversion.
//   - start while busy=1 is ignored; it is neither queued nor counted.
//  FSM: IDLE -> LOAD -> SHIFT -> COMMIT -> (next field, or UPDATE) -> IDLE.
//   - Fields are processed in the order A, B, C.
//   - LOAD (1 cycle): bcd=12'h000, bin=shadow field, shift count=0.
//   - SHIFT (WIDTH cycles): on each cycle, first add 3 to every bcd nibble >=5,
//     then shift {bcd,bin} left by 1.
//   - COMMIT (1 cycle): write tens/units into staging.
//     If the hundreds nibble !=0 (value >99), stage 4'hF,4'hF instead.
//   - UPDATE (1 cycle): copy staging to dig outputs; dig2=dig3=4'hF always.
//  Timing:
//   - busy is a registered output. It is 1 for exactly 3*(WIDTH+2)+1 = 31
//     cycles (WIDTH=8) starting the cycle after acceptance.
//   - In the cycle after UPDATE: busy=0, done=1 for one cycle, dig outputs hold the new values.
//   - start=1 in that done cycle is accepted (back-to-back, no idle gap).
//  Hold: dig outputs change only on UPDATE or on reset. Between conversions they hold their value.
//  Widths:
//   - Add-3 is per 4-bit nibble with no carry between nibbles.
//   - The maximum input 2^WIDTH-1 (<=511) fits in 3 nibbles.
// TESTING
//  1. After reset release: dig0..7=4'hF, busy=0, done=0.
//     start with A=42, B=7, C=99 -> 31 cycles later done=1;
//     dig1/0=4/2, dig5/4=0/7, dig7/6=9/9, dig2=dig3=F.
//  2. Overflow: A=100, B=255, C=0 -> dig1/0=F/F, dig5/4=F/F, dig7/6=0/0.
//  3. Pulse start on cycles 5 and 10 of a running conversion, with the val inputs changed ->
//     only one done pulse; digits match the values captured at the first start.
//  4. Back-to-back: hold start=1 continuously, changing vals each accept ->
//     done pulses every 32 cycles; each result matches its captured vals.
//  5. Drive reset_n=0 at cycle 15 of a conversion -> outputs immediately F, busy=0, no done.
//     A new start after release completes normally.
//  6. Exhaustive: sweep A over 0..2^WIDTH-1 (B, C random) ->
//     dig1/0 equals the BCD of A for A<=99, and F/F otherwise.

Source files
------------

// File: rtl/display_bcd_ctrl.sv
// Conversion sequencer for the 8-digit seven-segment driver: three binary fields are
// converted to two BCD digits each with one shared double-dabble engine, then published together.
module display_bcd_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] val_a,
    input  logic [WIDTH-1:0] val_b,
    input  logic [WIDTH-1:0] val_c,
    output logic             busy,
    output logic             done,
    output logic [3:0]       dig0,
    output logic [3:0]       dig1,
    output logic [3:0]       dig2,
    output logic [3:0]       dig3,
    output logic [3:0]       dig4,
    output logic [3:0]       dig5,
    output logic [3:0]       dig6,
    output logic [3:0]       dig7
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_COMMIT,
        S_UPDATE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sh_a_q, sh_a_d;
    logic [WIDTH-1:0] sh_b_q, sh_b_d;
    logic [WIDTH-1:0] sh_c_q, sh_c_d;
    logic [1:0]       field_q, field_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [11:0]      bcd_q, bcd_d;
    logic [WIDTH-1:0] bin_q, bin_d;
    logic [23:0]      stage_q, stage_d;
    logic [7:0][3:0]  dig_q, dig_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [11:0]      bcd_adj;
    logic [7:0]       pair;

    // Per-nibble correction; nibbles never carry into each other.
    function automatic logic [11:0] add3(input logic [11:0] v);
        logic [11:0] r;
        logic [3:0]  nib;
        r = '0;
        for (int unsigned i = 0; i < 3; i++) begin
            nib = v[4*i +: 4];
            if (nib >= 4'd5) begin
                nib = nib + 4'd3;
            end
            r[4*i +: 4] = nib;
        end
        return r;
    endfunction

    always_comb begin
        state_d = state_q;
        sh_a_d  = sh_a_q;
        sh_b_d  = sh_b_q;
        sh_c_d  = sh_c_q;
        field_d = field_q;
        cnt_d   = cnt_q;
        bcd_d   = bcd_q;
        bin_d   = bin_q;
        stage_d = stage_q;
        dig_d   = dig_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        bcd_adj = add3(bcd_q);
        // Values above 99 cannot be shown on two digits and become dashes.
        pair    = (bcd_q[11:8] != 4'd0) ? 8'hFF : bcd_q[7:0];

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    sh_a_d  = val_a;
                    sh_b_d  = val_b;
                    sh_c_d  = val_c;
                    field_d = 2'd0;
                    busy_d  = 1'b1;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                bcd_d = '0;
                cnt_d = '0;
                unique case (field_q)
                    2'd0:    bin_d = sh_a_q;
                    2'd1:    bin_d = sh_b_q;
                    default: bin_d = sh_c_q;
                endcase
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                bcd_d = {bcd_adj[10:0], bin_q[WIDTH-1]};
                bin_d = {bin_q[WIDTH-2:0], 1'b0};
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = S_COMMIT;
                end
            end
            S_COMMIT: begin
                unique case (field_q)
                    2'd0:    stage_d[7:0]   = pair;
                    2'd1:    stage_d[15:8]  = pair;
                    default: stage_d[23:16] = pair;
                endcase
                if (field_q == 2'd2) begin
                    state_d = S_UPDATE;
                end else begin
                    field_d = field_q + 2'd1;
                    state_d = S_LOAD;
                end
            end
            S_UPDATE: begin
                // Digits 2 and 3 are unused positions and always show a dash.
                dig_d   = {stage_q[23:8], 8'hFF, stage_q[7:0]};
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            sh_a_q  <= '0;
            sh_b_q  <= '0;
            sh_c_q  <= '0;
            field_q <= '0;
            cnt_q   <= '0;
            bcd_q   <= '0;
            bin_q   <= '0;
            stage_q <= '0;
            dig_q   <= '1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sh_a_q  <= sh_a_d;
            sh_b_q  <= sh_b_d;
            sh_c_q  <= sh_c_d;
            field_q <= field_d;
            cnt_q   <= cnt_d;
            bcd_q   <= bcd_d;
            bin_q   <= bin_d;
            stage_q <= stage_d;
            dig_q   <= dig_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign dig0 = dig_q[0];
    assign dig1 = dig_q[1];
    assign dig2 = dig_q[2];
    assign dig3 = dig_q[3];
    assign dig4 = dig_q[4];
    assign dig5 = dig_q[5];
    assign dig6 = dig_q[6];
    assign dig7 = dig_q[7];

endmodule

// File: tb/tb_display_bcd_ctrl.sv
// Scoreboard bench for display_bcd_ctrl: accepted requests push expected digits,
// a monitor pops and compares on every done pulse and checks digit hold between updates.
module tb_display_bcd_ctrl;

    localparam int unsigned WIDTH = 8;

    logic             clock = 1'b0;
    logic             reset_n = 1'b0;
    logic             start = 1'b0;
    logic [WIDTH-1:0] val_a = '0;
    logic [WIDTH-1:0] val_b = '0;
    logic [WIDTH-1:0] val_c = '0;
    logic             busy, done;
    logic [3:0]       dig0, dig1, dig2, dig3, dig4, dig5, dig6, dig7;

    int unsigned checks = 0;
    int unsigned errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] disp_exp = 32'hFFFF_FFFF;
    int unsigned busy_cnt = 0;
    int unsigned done_cnt = 0;

    display_bcd_ctrl #(.WIDTH(WIDTH)) dut (
        .clock(clock), .reset_n(reset_n), .start(start),
        .val_a(val_a), .val_b(val_b), .val_c(val_c),
        .busy(busy), .done(done),
        .dig0(dig0), .dig1(dig1), .dig2(dig2), .dig3(dig3),
        .dig4(dig4), .dig5(dig5), .dig6(dig6), .dig7(dig7)
    );

    always #5 clock = ~clock;

    function automatic logic [7:0] pair_of(input int unsigned v);
        if (v > 99) return 8'hFF;
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    function automatic logic [31:0] expect_digits(input int unsigned a, input int unsigned b,
                                                  input int unsigned c);
        return {pair_of(c), pair_of(b), 8'hFF, pair_of(a)};
    endfunction

    function automatic logic [31:0] dut_digits();
        return {dig7, dig6, dig5, dig4, dig3, dig2, dig1, dig0};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor + acceptance predictor, both sampled away from the active edge.
    always @(negedge clock) begin
        if (reset_n) begin
            if (done) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    disp_exp = exp_q.pop_front();
                    check("digits", dut_digits(), disp_exp);
                    check("busy_len", busy_cnt, 32'd31);
                    check("busy_at_done", {31'd0, busy}, 32'd0);
                end
                busy_cnt = 0;
                done_cnt++;
            end else begin
                check("hold", dut_digits(), disp_exp);
            end
            if (busy) busy_cnt++;
            if (start && !busy) begin
                exp_q.push_back(expect_digits(val_a, val_b, val_c));
            end
        end else begin
            busy_cnt = 0;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_idle();
        int unsigned n = 0;
        while ((busy || exp_q.size() != 0) && n < 200) begin
            tick();
            n++;
        end
        checks++;
        if (n >= 200) begin
            errors++;
            $display("FAIL wait_idle: got timeout expected done within 200 cycles");
        end
        tick();
    endtask

    task automatic convert(input int unsigned a, input int unsigned b, input int unsigned c);
        val_a = WIDTH'(a);
        val_b = WIDTH'(b);
        val_c = WIDTH'(c);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_idle();
    endtask

    initial begin
        int unsigned dn;
        int unsigned acc_wait;
        logic acc;

        repeat (3) tick();
        check("rst_digits", dut_digits(), 32'hFFFF_FFFF);
        check("rst_busy_done", {30'd0, busy, done}, 32'd0);
        reset_n = 1'b1;
        repeat (2) tick();
        check("post_rst_digits", dut_digits(), 32'hFFFF_FFFF);

        // Basic: 42/7/99 -> 4 2 / 0 7 / 9 9
        convert(42, 7, 99);
        check("basic_literal", dut_digits(), 32'h9907_FF42);

        // Overflow fields show dashes
        convert(100, 255, 0);
        check("ovf_literal", dut_digits(), 32'h00FF_FFFF);
        convert(99, 100, 10);

        // Starts during busy are ignored, inputs changed mid-conversion
        dn = done_cnt;
        val_a = 8'd13; val_b = 8'd57; val_c = 8'd80;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        val_a = 8'd1; val_b = 8'd2; val_c = 8'd3;
        start = 1'b1; tick(); start = 1'b0;
        repeat (4) tick();
        val_a = 8'd200; val_b = 8'd44; val_c = 8'd66;
        start = 1'b1; tick(); start = 1'b0;
        wait_idle();
        repeat (5) tick();
        check("single_done", done_cnt - dn, 32'd1);
        check("captured_vals", dut_digits(), 32'h8057_FF13);

        // Back-to-back with start held high
        dn = done_cnt;
        start = 1'b1;
        for (int k = 0; k < 4; k++) begin
            val_a = WIDTH'(11 * k + 5);
            val_b = WIDTH'(30 * k + 9);
            val_c = WIDTH'(97 + k);
            acc_wait = 0;
            do begin
                acc = !busy;
                tick();
                acc_wait++;
            end while (!acc && acc_wait < 100);
            if (k > 0) check("b2b_period", acc_wait, 32'd32);
        end
        start = 1'b0;
        wait_idle();
        check("b2b_dones", done_cnt - dn, 32'd4);

        // Reset in the middle of a conversion
        dn = done_cnt;
        val_a = 8'd77; val_b = 8'd88; val_c = 8'd66;
        start = 1'b1; tick(); start = 1'b0;
        repeat (14) tick();
        reset_n = 1'b0;
        exp_q.delete();
        disp_exp = 32'hFFFF_FFFF;
        #1;
        check("abort_digits", dut_digits(), 32'hFFFF_FFFF);
        check("abort_busy_done", {30'd0, busy, done}, 32'd0);
        repeat (3) tick();
        reset_n = 1'b1;
        repeat (40) tick();
        check("abort_no_done", done_cnt - dn, 32'd0);
        convert(12, 34, 56);
        check("after_abort", dut_digits(), 32'h5634_FF12);

        // Sweep A across the full input range
        for (int a = 0; a < (1 << WIDTH); a++) begin
            convert(a, $urandom_range(0, (1 << WIDTH) - 1), $urandom_range(0, (1 << WIDTH) - 1));
            check("sweep_a", {24'd0, dig1, dig0}, {24'd0, pair_of(a)});
        end

        check("queue_empty", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
